// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch stage and the decoder.
package ifetch_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned PC_INC = 4;

    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } ifu_state_e;

endpackage : ifetch_pkg

// File: rtl/pc_next_sel.sv
// Next-PC selection: redirect target, optional direct jump, else pc+4.
// Optional feature: define IFETCH_JUMP_EN to follow j/jal targets at fetch.
module pc_next_sel
    import ifetch_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rdata,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    output logic [XLEN-1:0] next_pc_c
);

    logic [XLEN-1:0] pc_plus4;
    logic            unused_bits;

    assign pc_plus4 = pc + XLEN'(PC_INC);

`ifdef IFETCH_JUMP_EN
    assign unused_bits = ^br_target[1:0];
`else
    assign unused_bits = ^{rdata, br_target[1:0]};
`endif

    // Redirect has priority over any jump found in the fetched word.
    always_comb begin
        next_pc_c = pc_plus4;
        if (br_taken) begin
            next_pc_c = {br_target[XLEN-1:2], 2'b00};
        end
`ifdef IFETCH_JUMP_EN
        else if ((rdata[31:26] == OP_J) || (rdata[31:26] == OP_JAL)) begin
            next_pc_c = {pc_plus4[31:28], rdata[25:0], 2'b00};
        end
`endif
    end

endmodule : pc_next_sel

// File: rtl/instr_fetch_unit.sv
// Multicycle instruction fetch: PC, imem req/ack, instruction register, EU handshake.
// Optional feature: IFETCH_JUMP_EN (direct j/jal following in pc_next_sel).
module instr_fetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    input  logic        br_taken,
    input  logic [31:0] br_target
);

    ifu_state_e  state;
    logic [31:0] pc;
    logic [31:0] redir;
    logic [31:0] next_pc_c;

    pc_next_sel u_pc_next_sel (
        .pc        (pc),
        .rdata     (imem_rdata),
        .br_taken  (br_taken),
        .br_target (br_target),
        .next_pc_c (next_pc_c)
    );

    // The fetch address is the PC register itself, so it only moves when pc does.
    assign imem_addr = pc;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm16  = instr[15:0];

    // Fetch FSM with registered req/valid and instruction register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            redir    <= '0;
            imem_req <= 1'b0;
            ir_valid <= 1'b0;
            instr    <= '0;
            pc_out   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        pc <= next_pc_c;
                        if (!br_taken) begin
                            instr    <= imem_rdata;
                            pc_out   <= pc;
                            imem_req <= 1'b0;
                            ir_valid <= 1'b1;
                            state    <= HOLD;
                        end
                    end else if (br_taken) begin
                        // Request is in flight: keep addr stable and drain it first.
                        redir <= {br_target[31:2], 2'b00};
                        state <= DRAIN;
                    end
                end
                HOLD: begin
                    if (br_taken || ir_ready) begin
                        if (br_taken) begin
                            pc <= next_pc_c;
                        end
                        ir_valid <= 1'b0;
                        imem_req <= 1'b1;
                        state    <= FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        pc    <= br_taken ? next_pc_c : redir;
                        state <= FETCH;
                    end else if (br_taken) begin
                        redir <= {br_target[31:2], 2'b00};
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// Cycle-table bench for instr_fetch_unit plus hand sequences for jump handling.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic        br_taken;
    logic [31:0] br_target;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .instr      (instr),
        .pc_out     (pc_out),
        .opcode     (opcode),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .shamt      (shamt),
        .funct      (funct),
        .imm16      (imm16),
        .br_taken   (br_taken),
        .br_target  (br_target)
    );

    // One row = one clock cycle: inputs driven this cycle, outputs expected this cycle.
    typedef struct {
        logic        chk;
        logic        rst;
        logic        ack;
        logic [31:0] rdata;
        logic        rdy;
        logic        br;
        logic [31:0] tgt;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] ins;
        logic [31:0] pco;
    } vec_t;

    vec_t vecs[$];

    task automatic row(input logic chk, input logic rst, input logic ack, input logic [31:0] rdata,
                       input logic rdy, input logic br, input logic [31:0] tgt,
                       input logic req, input logic [31:0] addr, input logic vld,
                       input logic [31:0] ins, input logic [31:0] pco);
        vec_t v;
        v.chk = chk; v.rst = rst; v.ack = ack; v.rdata = rdata; v.rdy = rdy; v.br = br; v.tgt = tgt;
        v.req = req; v.addr = addr; v.vld = vld; v.ins = ins; v.pco = pco;
        vecs.push_back(v);
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic ack, input logic [31:0] rdata,
                         input logic rdy, input logic br, input logic [31:0] tgt);
        reset = rst; imem_ack = ack; imem_rdata = rdata; ir_ready = rdy; br_taken = br; br_target = tgt;
    endtask

    localparam logic [31:0] W0 = 32'h2008_FFFC;
    localparam logic [31:0] W1 = 32'h0000_0020;
    localparam logic [31:0] W2 = 32'hAAAA_5555;
    localparam logic [31:0] WJ = 32'h0800_0010;
    localparam logic [31:0] WJAL = 32'h0C00_0020;

`ifdef IFETCH_JUMP_EN
    localparam logic [31:0] J_NEXT = 32'h0000_0040;
`else
    localparam logic [31:0] J_NEXT = 32'h0000_0004;
`endif

    initial begin
        drive(1'b1, 1'b1, '0, 1'b0, 1'b0, '0);

        //  chk rst ack rdata          rdy br  tgt            req  addr           vld  instr  pc_out
        row(0, 1, 1, 32'h0,           0, 0, 32'h0,          0, 32'h0,          0, 32'h0, 32'h0);
        row(1, 1, 1, 32'h0,           0, 0, 32'h0,          0, 32'h0,          0, 32'h0, 32'h0);
        row(1, 1, 1, 32'h0,           0, 0, 32'h0,          0, 32'h0,          0, 32'h0, 32'h0);
        row(1, 0, 1, 32'h1111_1111,   0, 0, 32'h0,          0, 32'h0,          0, 32'h0, 32'h0);  // IDLE
        row(1, 0, 1, W0,              0, 0, 32'h0,          1, 32'h0,          0, 32'h0, 32'h0);  // FETCH @0
        for (int k = 0; k < 5; k++)
            row(1, 0, 0, 32'h0,       0, 0, 32'h0,          0, 32'h4,          1, W0,    32'h0);  // back-pressure
        row(1, 0, 0, 32'h0,           1, 0, 32'h0,          0, 32'h4,          1, W0,    32'h0);  // accept
        row(1, 0, 0, 32'h0,           0, 0, 32'h0,          1, 32'h4,          0, W0,    32'h0);  // FETCH @4, no ack
        row(1, 0, 0, 32'h0,           0, 0, 32'h0,          1, 32'h4,          0, W0,    32'h0);
        row(1, 0, 1, W1,              0, 0, 32'h0,          1, 32'h4,          0, W0,    32'h0);
        row(1, 0, 0, 32'h0,           1, 1, 32'h0000_0103,  0, 32'h8,          1, W1,    32'h4);  // redirect+ready
        row(1, 0, 1, 32'h1234_5678,   0, 1, 32'hFFFF_FFFF,  1, 32'h100,        0, W1,    32'h4);  // ack+redirect
        row(1, 0, 1, W2,              0, 0, 32'h0,          1, 32'hFFFF_FFFC,  0, W1,    32'h4);  // FETCH top word
        row(1, 0, 0, 32'h0,           1, 0, 32'h0,          0, 32'h0,          1, W2,    32'hFFFF_FFFC);  // wrapped
        row(1, 0, 0, 32'h0,           0, 1, 32'h0000_0200,  1, 32'h0,          0, W2,    32'hFFFF_FFFC);  // -> DRAIN
        row(1, 0, 0, 32'h0,           0, 0, 32'h0,          1, 32'h0,          0, W2,    32'hFFFF_FFFC);
        row(1, 0, 0, 32'h0,           0, 1, 32'h0000_0304,  1, 32'h0,          0, W2,    32'hFFFF_FFFC);  // overwrite
        row(1, 0, 1, 32'hDEAD_BEEF,   0, 0, 32'h0,          1, 32'h0,          0, W2,    32'hFFFF_FFFC);  // stale ack
        row(1, 1, 1, 32'h0,           0, 0, 32'h0,          1, 32'h304,        0, W2,    32'hFFFF_FFFC);  // reset mid-fetch
        row(1, 0, 1, 32'h0,           0, 0, 32'h0,          0, 32'h0,          0, 32'h0, 32'h0);  // IDLE
        row(1, 0, 0, 32'h0,           0, 0, 32'h0,          1, 32'h0,          0, 32'h0, 32'h0);  // FETCH @0

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].ack, vecs[i].rdata, vecs[i].rdy, vecs[i].br, vecs[i].tgt);
            if (vecs[i].chk) begin
                n_vec++;
                if (imem_req !== vecs[i].req || imem_addr !== vecs[i].addr || ir_valid !== vecs[i].vld ||
                    instr !== vecs[i].ins || pc_out !== vecs[i].pco) begin
                    n_err++;
                    $display("FAIL row %0d: req=%b addr=%h vld=%b instr=%h pc_out=%h, expected req=%b addr=%h vld=%b instr=%h pc_out=%h",
                             i, imem_req, imem_addr, ir_valid, instr, pc_out,
                             vecs[i].req, vecs[i].addr, vecs[i].vld, vecs[i].ins, vecs[i].pco);
                end
            end
            if (i == 5) begin
                chk32("imm16_first", 32'(imm16), 32'h0000_FFFC);
                chk32("rt_first", 32'(rt), 32'd8);
                chk32("opcode_first", 32'(opcode), 32'd8);
                chk32("rd_first", 32'(rd), 32'd31);
                chk32("funct_first", 32'(funct), 32'h3C);
            end
        end

        // Jump word fetched at pc 0: presented to the EU; next address depends on the feature.
        @(negedge clk);
        drive(1'b0, 1'b1, WJ, 1'b0, 1'b0, '0);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        chk32("jump_valid", 32'(ir_valid), 32'd1);
        chk32("jump_instr", instr, WJ);
        chk32("jump_pc_out", pc_out, 32'h0);
        chk32("jump_opcode", 32'(opcode), 32'd2);
        chk32("jump_funct", 32'(funct), 32'h10);
        ir_ready = 1'b1;
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        chk32("jump_next_req", 32'(imem_req), 32'd1);
        chk32("jump_next_addr", imem_addr, J_NEXT);

        // jal returned together with a redirect: the redirect wins and the word is dropped.
        drive(1'b0, 1'b1, WJAL, 1'b0, 1'b1, 32'h0000_0502);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        chk32("jal_br_valid", 32'(ir_valid), 32'd0);
        chk32("jal_br_req", 32'(imem_req), 32'd1);
        chk32("jal_br_addr", imem_addr, 32'h0000_0500);
        chk32("jal_br_instr", instr, WJ);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_instr_fetch_unit
